// File: rtl/byte_serial_lsu.sv
// byte_serial_lsu
// ---------------------------------------------------------------------------
// Load/store initiator that connects the MEM stage to a byte-wide data memory.
// It accepts one word-sized request at a time and performs it as BYTE_SIZE
// single-byte accesses. The accesses are little-endian: byte i goes to
// address base+i. The load word, or a store completion, comes back through a
// second valid/ready handshake.
//
// Optional feature (compile-time macro):
//   LSU_ALIGN_CHECK_EN - when defined, a request whose address is not a
//                        multiple of BYTE_SIZE is rejected. It gets an error
//                        response one cycle after acceptance and makes no
//                        memory access. When undefined, every address is
//                        serviced and resp_err is tied to 0.
//
// Parameters:
//   BYTE_SIZE   bytes per request word (data width = BYTE_SIZE*8)
//   ADDR_WIDTH  byte-address width
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   reset        asynchronous active-high reset, returns to IDLE at once
//   req_valid    request present
//   req_ready    unit can accept a request (IDLE only)
//   req_we       1 = store, 0 = load
//   req_addr     base byte address
//   req_wdata    store data, byte k = bits [8k+7:8k]
//   resp_valid   response present
//   resp_ready   consumer takes the response
//   resp_rdata   assembled load word, 0 for stores and errors
//   resp_err     request rejected (alignment check only)
//   mem_addr     byte address to memory (0 outside ACCESS)
//   mem_we       byte write enable to memory (0 outside ACCESS)
//   mem_wd       byte write data to memory (0 outside ACCESS)
//   mem_rd       byte read data from memory, combinational in mem_addr
//
// Every output is decoded from registered state only. No combinational path
// runs from req_* or resp_ready to any output.
// ---------------------------------------------------------------------------
module byte_serial_lsu #(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [BYTE_SIZE*8-1:0]  req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [BYTE_SIZE*8-1:0]  resp_rdata,
    output logic                    resp_err,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [7:0]              mem_wd,
    input  logic [7:0]              mem_rd
);

    localparam int DATA_WIDTH = BYTE_SIZE * 8;
    localparam int CNT_WIDTH  = (BYTE_SIZE > 1) ? $clog2(BYTE_SIZE) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BYTE_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   req_bad;

`ifdef LSU_ALIGN_CHECK_EN
    logic                   err_q;

    // A request is misaligned when its base is not a whole multiple of the
    // word size. Such a request bypasses ACCESS entirely.
    assign req_bad = (req_addr % ADDR_WIDTH'(BYTE_SIZE)) != '0;
`else
    assign req_bad = 1'b0;
`endif

    // State register. Reset forces IDLE immediately. mem_we is decoded from
    // the state, so it also drops as soon as reset is asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. The last byte access (cnt == BYTE_SIZE-1) moves to
    // RESP. The response then holds until the consumer takes it.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_next = req_bad ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == LAST_CNT) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, byte counter and load assembly. rdata_q is cleared on
    // acceptance, so stores and rejected requests always report zero. Each
    // load byte is captured at the end of the cycle in which its address is
    // driven.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            base_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef LSU_ALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        base_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt     <= '0;
                        rdata_q <= '0;
`ifdef LSU_ALIGN_CHECK_EN
                        err_q   <= req_bad;
`endif
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        for (int k = 0; k < BYTE_SIZE; k++) begin
                            if (cnt == CNT_WIDTH'(k)) begin
                                rdata_q[8*k +: 8] <= mem_rd;
                            end
                        end
                    end
                    cnt <= cnt + CNT_WIDTH'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Memory port decode. The address is base+cnt truncated to ADDR_WIDTH,
    // so a request near the top of the address space wraps to 0. All three
    // signals are held at zero outside ACCESS.
    always_comb begin
        mem_addr = '0;
        mem_we   = 1'b0;
        mem_wd   = '0;
        if (state == ACCESS) begin
            mem_addr = base_q + ADDR_WIDTH'(cnt);
            mem_we   = we_q;
            for (int k = 0; k < BYTE_SIZE; k++) begin
                if (cnt == CNT_WIDTH'(k)) begin
                    mem_wd = wdata_q[8*k +: 8];
                end
            end
        end
    end

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_rdata = ((state == RESP) && !we_q) ? rdata_q : '0;

`ifdef LSU_ALIGN_CHECK_EN
    assign resp_err   = (state == RESP) && err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_byte_serial_lsu.sv
// tb_byte_serial_lsu
// ---------------------------------------------------------------------------
// Directed testbench for byte_serial_lsu with default parameters
// (BYTE_SIZE=4, ADDR_WIDTH=32). A small 256-byte memory, indexed by the low
// address byte, answers the byte port. It reads combinationally and writes
// on the rising edge. Word requests come from a table of records. Reset,
// address wrap and alignment rejection use hand-written sequences. The
// alignment sequence follows LSU_ALIGN_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_byte_serial_lsu;

    localparam int BYTE_SIZE  = 4;
    localparam int ADDR_WIDTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wd;
    logic [7:0]  mem_rd;

    logic [7:0]  mem_arr [0:255];
    logic        tb_wr_en = 1'b0;
    logic [7:0]  tb_wr_addr = 8'h00;
    logic [7:0]  tb_wr_data = 8'h00;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          hold;
    } vec_t;

    vec_t vecs [7];

    byte_serial_lsu #(
        .BYTE_SIZE (BYTE_SIZE),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
    );

    always #5 clk = ~clk;

    // Byte memory. The bench preload port has priority over the DUT port.
    // Preloads only happen while the DUT is idle.
    always @(posedge clk) begin
        if (tb_wr_en) begin
            mem_arr[tb_wr_addr] <= tb_wr_data;
        end else if (mem_we) begin
            mem_arr[mem_addr[7:0]] <= mem_wd;
        end
    end

    assign mem_rd = mem_arr[mem_addr[7:0]];

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endfunction

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        tb_wr_en   = 1'b1;
        tb_wr_addr = a;
        tb_wr_data = d;
        @(negedge clk);
        tb_wr_en   = 1'b0;
    endtask

    // Runs one request from a falling edge with the DUT idle. It checks
    // every byte cycle, the response cycle, optional back-pressure cycles
    // (during which a stray store request is offered), and the return to
    // IDLE.
    task automatic applyStimulus(input vec_t v);
        logic [31:0] ea;
        logic [31:0] held;
        checkOutput("req_ready idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        if (!v.exp_err) begin
            for (int k = 0; k < BYTE_SIZE; k++) begin
                ea = v.addr + 32'(k);
                checkOutput("mem_addr", mem_addr, ea);
                checkOutput("mem_we", 32'(mem_we), 32'(v.we));
                checkOutput("mem_wd", 32'(mem_wd), 32'(v.wdata[8*k +: 8]));
                checkOutput("resp_valid early", 32'(resp_valid), 32'd0);
                checkOutput("req_ready busy", 32'(req_ready), 32'd0);
                @(negedge clk);
            end
        end
        checkOutput("resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("resp_rdata", resp_rdata, v.exp_rdata);
        checkOutput("resp_err", 32'(resp_err), 32'(v.exp_err));
        checkOutput("mem_we in resp", 32'(mem_we), 32'd0);
        checkOutput("req_ready resp", 32'(req_ready), 32'd0);
        held = resp_rdata;
        for (int h = 0; h < v.hold; h++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 32'h8;
            req_wdata = 32'h0;
            @(negedge clk);
            checkOutput("hold resp_valid", 32'(resp_valid), 32'd1);
            checkOutput("hold resp_rdata", resp_rdata, v.exp_rdata);
            checkOutput("hold rdata stable", resp_rdata, held);
            checkOutput("hold req_ready", 32'(req_ready), 32'd0);
            checkOutput("hold mem_we", 32'(mem_we), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        checkOutput("resp_valid after", 32'(resp_valid), 32'd0);
        checkOutput("req_ready after", 32'(req_ready), 32'd1);
    endtask

    initial begin
        vec_t v;

        //            we    addr          wdata         exp_rdata     err   hold
        vecs[0] = '{1'b1, 32'h0000_0008, 32'hDDCC_BBAA, 32'h0000_0000, 1'b0, 0};
        vecs[1] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 32'hDDCC_BBAA, 1'b0, 0};
        vecs[2] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0000_0000, 1'b0, 0};
        vecs[3] = '{1'b0, 32'h0000_0020, 32'h5A5A_5A5A, 32'h1234_5678, 1'b0, 3};
        vecs[4] = '{1'b0, 32'h0000_0008, 32'h0000_0000, 32'hDDCC_BBAA, 1'b0, 0};
        vecs[5] = '{1'b1, 32'h0000_0040, 32'h0000_00FF, 32'h0000_0000, 1'b0, 0};
        vecs[6] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 32'h0000_00FF, 1'b0, 0};

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        resp_ready = 1'b0;
        #2;
        checkOutput("reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset resp_rdata", resp_rdata, 32'd0);
        checkOutput("reset resp_err", 32'(resp_err), 32'd0);
        checkOutput("reset mem_addr", mem_addr, 32'd0);
        checkOutput("reset mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset mem_wd", 32'(mem_wd), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
        end

`ifdef LSU_ALIGN_CHECK_EN
        // A misaligned store is rejected without touching memory.
        preload(8'h05, 8'h77);
        v = '{1'b1, 32'h0000_0005, 32'h1111_1111, 32'h0000_0000, 1'b1, 0};
        applyStimulus(v);
        checkOutput("misaligned byte untouched", 32'(mem_arr[8'h05]), 32'h77);
        v = '{1'b0, 32'h0000_0008, 32'h0000_0000, 32'hDDCC_BBAA, 1'b0, 0};
        applyStimulus(v);
`else
        // A load near the top of the address space wraps to 0.
        preload(8'hFE, 8'h11);
        preload(8'hFF, 8'h22);
        preload(8'h00, 8'h33);
        preload(8'h01, 8'h44);
        v = '{1'b0, 32'hFFFF_FFFE, 32'h0000_0000, 32'h4433_2211, 1'b0, 0};
        applyStimulus(v);
`endif

        // Reset in the middle of a store. Bytes 0 and 1 are already written.
        // Bytes 2 and 3 keep their old contents.
        preload(8'h10, 8'h01);
        preload(8'h11, 8'h02);
        preload(8'h12, 8'h03);
        preload(8'h13, 8'h04);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'hA4A3_A2A1;
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        checkOutput("rst seq addr0", mem_addr, 32'h10);
        @(negedge clk);
        checkOutput("rst seq addr1", mem_addr, 32'h11);
        checkOutput("rst seq we1", 32'(mem_we), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("rst seq we2 before", 32'(mem_we), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst mem_we drop", 32'(mem_we), 32'd0);
        checkOutput("rst mem_addr", mem_addr, 32'd0);
        checkOutput("rst req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("post-rst resp_valid", 32'(resp_valid), 32'd0);
            checkOutput("post-rst mem_we", 32'(mem_we), 32'd0);
        end
        checkOutput("rst byte 0x10", 32'(mem_arr[8'h10]), 32'hA1);
        checkOutput("rst byte 0x11", 32'(mem_arr[8'h11]), 32'hA2);
        checkOutput("rst byte 0x12", 32'(mem_arr[8'h12]), 32'h03);
        checkOutput("rst byte 0x13", 32'(mem_arr[8'h13]), 32'h04);
        v = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0403_A2A1, 1'b0, 0};
        applyStimulus(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
